lcd_bus_decoder: RTL

- Responder side of the 4-bit character-LCD write bus (LCD_E/LCD_RS/LCD_RW/SF_D) that the LCD driver produces.
- Decodes nibble strobes into command and data bytes, tracks the DDRAM cursor, and mirrors the visible 2x16 characters in a shadow buffer.
- Used as a synthesizable bus monitor for on-board self-check and as the checker endpoint in watch-display benches.

---
 rtl/lcd_bus_decoder_if.sv | 11 +
 rtl/lcd_bus_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_decoder_if.sv
// 4-bit character-LCD write bus (LCD_E / LCD_RS / LCD_RW / SF_D).
// The master modport is the LCD driver side; the slave modport is the listener.
interface lcd_bus_decoder_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] SF_D;

    modport master (output LCD_E, output LCD_RS, output LCD_RW, output SF_D);
    modport slave  (input  LCD_E, input  LCD_RS, input  LCD_RW, input  SF_D);
endinterface

// File: rtl/lcd_bus_decoder.sv
// Responder for the 4-bit character-LCD write bus.
// - Rebuilds command/data bytes from nibble strobes on the falling edge of LCD_E.
// - Tracks the DDRAM cursor.
// - Mirrors the visible 2x16 characters in a shadow buffer.
// Optional feature macro LCD_DEC_CLEAR_EN:
// - Defined: the clear command runs a 32-cycle blank fill and drives busy.
// - Undefined: the clear command behaves as home, and busy stays 0.
module lcd_bus_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
    input  logic                CLK,
    input  logic                RST,
    lcd_bus_decoder_if.slave    lcd,
    output logic                byte_valid,
    output logic [7:0]          byte_data,
    output logic                byte_rs,
    output logic [6:0]          cur_addr,
    output logic                init_done,
    output logic                busy,
    output logic                proto_err,
    input  logic [4:0]          rd_idx,
    output logic [7:0]          rd_char
);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    // Next DDRAM address after a data write.
    // Line 1 spans 0x00..0x27 and line 2 spans 0x40..0x67; each end wraps to the other line.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (a == 7'h27)      n = 7'h40;
            else if (a == 7'h67) n = 7'h00;
            else                 n = a + 7'd1;
        end else begin
            if (a == 7'h00)      n = 7'h67;
            else if (a == 7'h40) n = 7'h27;
            else                 n = a - 7'd1;
        end
        return n;
    endfunction

    // Columns 0x28..0x3F on either line do not exist.
    function automatic logic addr_hole(input logic [6:0] a);
        return (a[5:0] >= 6'h28);
    endfunction

    // A set-address into a hole snaps to the start of that line.
    function automatic logic [6:0] addr_clamp(input logic [6:0] a);
        return addr_hole(a) ? (a & 7'h40) : a;
    endfunction

    logic       e_sync  [SYNC_STAGES];
    logic       rs_sync [SYNC_STAGES];
    logic       rw_sync [SYNC_STAGES];
    logic [3:0] d_sync  [SYNC_STAGES];
    logic       e_last_p0;

    logic [1:0] state;
    logic [3:0] hi_nib;
    logic       hi_rs;
    logic       id_inc;

    logic       fill_busy;
    logic [4:0] fill_idx;

    logic [7:0]  shadow_mem [32];
    logic [31:0] shadow_vld;

    logic       strobe_p0;
    logic       rs_in;
    logic       rw_in;
    logic [3:0] nib_in;
    logic [7:0] byte_now;
    logic       byte_done;
    logic       act_en;
    logic       wr_en;
    logic [4:0] wr_idx;

    assign busy = fill_busy;

    // Enable-line synchroniser and edge history; cleared so reset never fakes a strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) e_sync[i] <= 1'b0;
            e_last_p0 <= 1'b0;
        end else begin
            e_sync[0] <= lcd.LCD_E;
            for (int i = 1; i < SYNC_STAGES; i++) e_sync[i] <= e_sync[i-1];
            e_last_p0 <= e_sync[SYNC_STAGES-1];
        end
    end

    // Qualifier synchroniser; only looked at when a strobe is present.
    always_ff @(posedge CLK) begin
        rs_sync[0] <= lcd.LCD_RS;
        rw_sync[0] <= lcd.LCD_RW;
        d_sync[0]  <= lcd.SF_D;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rs_sync[i] <= rs_sync[i-1];
            rw_sync[i] <= rw_sync[i-1];
            d_sync[i]  <= d_sync[i-1];
        end
    end

    // ---- stage p0: strobe detect and byte assembly
    // Strobe decode and shadow-write qualification for the current cycle.
    always_comb begin
        strobe_p0 = e_last_p0 & ~e_sync[SYNC_STAGES-1];
        rs_in     = rs_sync[SYNC_STAGES-1];
        rw_in     = rw_sync[SYNC_STAGES-1];
        nib_in    = d_sync[SYNC_STAGES-1];
        byte_now  = {hi_nib, nib_in};
        byte_done = strobe_p0 & ~rw_in & (state == ST_LO);
        act_en    = byte_done & ~fill_busy;
        wr_en     = act_en & rs_in & (cur_addr[5:0] < 6'd16);
        wr_idx    = {cur_addr[6], cur_addr[3:0]};
    end

    // ---- stage p1: byte report, cursor update and error flags
    // Nibble FSM, byte reporting and command/data actions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_INIT;
            init_done  <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_rs    <= 1'b0;
            cur_addr   <= 7'h00;
            id_inc     <= 1'b1;
            proto_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (strobe_p0 && rw_in) begin
                proto_err <= 1'b1;
            end else if (strobe_p0) begin
                case (state)
                    ST_INIT: begin
                        if (rs_in) begin
                            proto_err <= 1'b1;
                        end else if (nib_in == 4'h2) begin
                            state     <= ST_HI;
                            init_done <= 1'b1;
                        end
                    end
                    ST_HI: begin
                        hi_nib <= nib_in;
                        hi_rs  <= rs_in;
                        state  <= ST_LO;
                    end
                    ST_LO: begin
                        state      <= ST_HI;
                        byte_valid <= 1'b1;
                        byte_data  <= byte_now;
                        byte_rs    <= rs_in;
                        if (rs_in != hi_rs) proto_err <= 1'b1;
                        if (fill_busy) begin
                            proto_err <= 1'b1;
                        end else if (rs_in) begin
                            cur_addr <= addr_step(cur_addr, id_inc);
                        end else if (byte_now[7]) begin
                            cur_addr <= addr_clamp(byte_now[6:0]);
                            if (addr_hole(byte_now[6:0])) proto_err <= 1'b1;
                        end else if (byte_now == 8'h01) begin
                            cur_addr <= 7'h00;
                            id_inc   <= 1'b1;
                        end else if (byte_now[7:1] == 7'b0000001) begin
                            cur_addr <= 7'h00;
                        end else if (byte_now[7:2] == 6'b000001) begin
                            id_inc <= byte_now[1];
                        end
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

`ifdef LCD_DEC_CLEAR_EN
    logic clear_go;
    assign clear_go = act_en & ~rs_in & (byte_now == 8'h01);

    // Clear sequencer: busy for exactly 32 cycles, one blank entry per cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fill_busy <= 1'b0;
            fill_idx  <= 5'd0;
        end else if (clear_go) begin
            fill_busy <= 1'b1;
            fill_idx  <= 5'd0;
        end else if (fill_busy) begin
            fill_idx <= fill_idx + 5'd1;
            if (fill_idx == 5'd31) fill_busy <= 1'b0;
        end
    end
`else
    assign fill_busy = 1'b0;
    assign fill_idx  = 5'd0;
`endif

    // Shadow character storage; the fill and data writes never overlap.
    always_ff @(posedge CLK) begin
        if (fill_busy)  shadow_mem[fill_idx] <= BLANK_CHAR;
        else if (wr_en) shadow_mem[wr_idx]   <= byte_now;
    end

    // Per-entry written flags; unwritten entries read back as blank after reset.
    always_ff @(posedge CLK) begin
        if (RST)        shadow_vld <= 32'h0;
        else if (fill_busy) shadow_vld[fill_idx] <= 1'b1;
        else if (wr_en) shadow_vld[wr_idx]   <= 1'b1;
    end

    // Registered read port.
    always_ff @(posedge CLK) begin
        rd_char <= shadow_vld[rd_idx] ? shadow_mem[rd_idx] : BLANK_CHAR;
    end

endmodule
